regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with an integrated busy scoreboard for the pipelined MIPS core. Two write ports (writeback and a second retire path), NR combinational read ports with same-cycle write bypass, and one busy bit per register that is set at instruction issue and cleared at writeback. Register 0 is hardwired to zero and never busy. Sits between decode/issue (read, busy check, issue) and writeback (both write ports).

## Interface
Parameters:
- DW, 32, data width of each register
- AW, 5, address width; depth = 2**AW
- NR, 3, number of read ports

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- WE_A  in  1  write enable, port A
- WA_A  in  AW  write address, port A
- WD_A  in  DW  write data, port A
- WE_B  in  1  write enable, port B (priority port)
- WA_B  in  AW  write address, port B
- WD_B  in  DW  write data, port B
- RA  in  NR*AW  read addresses; port i at bits [i*AW +: AW]
- RD  out  NR*DW  read data; port i at bits [i*DW +: DW]
- RBUSY  out  NR  busy flag of the register addressed by read port i
- ISS_EN  in  1  issue strobe: mark ISS_A busy
- ISS_A  in  AW  destination register of the issuing instruction
- NBUSY  out  AW+1  count of busy registers

## Operation
- Storage: 2**AW x DW registers plus 2**AW busy bits; entry 0 of both is constant 0.
- Writes: on rising CLK, WE_A writes WD_A to WA_A; WE_B writes WD_B to WA_B. Same address on both with both enabled: port B value stored. Writes to address 0 have no effect.
- Busy clear: any enabled write (A or B) to address n≠0 clears busy[n] at that edge.
- Busy set: ISS_EN with ISS_A≠0 sets busy[ISS_A] at that edge. Set and clear of the same register on the same edge: set wins (new producer replaces old one). ISS_A=0 ignored.
- Read port i, combinational:
  - RA_i = 0: RD_i = 0, RBUSY_i = 0.
  - else if WE_B and WA_B = RA_i: RD_i = WD_B.
  - else if WE_A and WA_A = RA_i: RD_i = WD_A.
  - else RD_i = rf[RA_i].
  - RBUSY_i = busy[RA_i] and not (a write to RA_i is enabled this cycle). Issue in the same cycle does not affect RBUSY_i until after the edge.
- NBUSY: registered population count of busy bits, updated on the same edge as the busy bits (reflects post-edge state; zero-latency relative to busy array, one cycle after ISS_EN/write).
- Width rules: NBUSY max value 2**AW−1, fits AW+1 bits; no saturation needed.

## Timing
- Reset (RST_N low, asynchronous): all registers = 0, all busy bits = 0, NBUSY = 0; RD_i = 0 and RBUSY_i = 0 for all i while held, except bypassed write data still reaches RD combinationally. Inputs ignored at edges while RST_N is low. Reset asserted mid-sequence discards pending busy state; no recovery of in-flight writes.
- Reset release: first edge with RST_N high performs normal writes/issues.
- Write latency: stored at the edge; visible combinationally in the same cycle via bypass, from storage thereafter.
- Busy latency: ISS_EN at edge k → RBUSY high from after edge k; write at edge m → RBUSY low in cycle m (bypass) and stays low after.
- No handshakes; stalls are decided by the consumer from RBUSY.

## Test plan
- Reset: drive writes 0xDEADBEEF to r5, assert RST_N low asynchronously mid-cycle → RD for RA=5 reads 0, NBUSY=0 immediately without an edge.
- Zero register: WE_A, WA_A=0, WD_A=0x12345678; ISS_EN, ISS_A=0 → RA=0 reads 0, RBUSY=0, NBUSY unchanged.
- Bypass and priority: same cycle WE_A r7=0x11, WE_B r7=0x22 → RD(r7)=0x22 in that cycle and after the edge; WE_A alone r8=0x33 → RD(r8)=0x33 same cycle.
- Scoreboard: ISS r3 at edge 1 → RBUSY(r3)=1, NBUSY=1; WE_A r3=0xA5 in cycle 4 → RBUSY(r3)=0 and RD=0xA5 in cycle 4, NBUSY=0 after edge 4.
- Set-wins: r9 busy; same cycle WE_B r9=0x55 and ISS_EN r9 → after edge r9 holds 0x55, RBUSY(r9)=1, NBUSY unchanged.
- Fill: issue r1..r31 on consecutive edges → NBUSY=31; then write all via A and B two per cycle → NBUSY decreases by 2 each edge to 0; all three read ports return written values.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass and a busy scoreboard for the MIPS issue stage.
// Register 0 always reads as zero and is never busy. NBUSY is the registered count of busy registers.

module regfile_mp_rd #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic [AW-1:0]              ra,
  input  logic                       we_a,
  input  logic [AW-1:0]              wa_a,
  input  logic [DW-1:0]              wd_a,
  input  logic                       we_b,
  input  logic [AW-1:0]              wa_b,
  input  logic [DW-1:0]              wd_b,
  input  logic [DEPTH-1:0][DW-1:0]   rf,
  input  logic [DEPTH-1:0]           busy,
  output logic [DW-1:0]              rd,
  output logic                       rbusy
);
  logic hit_a, hit_b;

  assign hit_a = we_a && (wa_a == ra);
  assign hit_b = we_b && (wa_b == ra);

  always_comb begin
    rd    = '0;
    rbusy = 1'b0;
    if (ra != '0) begin
      if (hit_b)      rd = wd_b;
      else if (hit_a) rd = wd_a;
      else            rd = rf[ra];
      // A write landing this cycle retires the producer, so the consumer need not stall.
      rbusy = busy[ra] && !(hit_a || hit_b);
    end
  end
endmodule

module regfile_mp #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE_A,
  input  logic [AW-1:0]    WA_A,
  input  logic [DW-1:0]    WD_A,
  input  logic             WE_B,
  input  logic [AW-1:0]    WA_B,
  input  logic [DW-1:0]    WD_B,
  input  logic [NR*AW-1:0] RA,
  output logic [NR*DW-1:0] RD,
  output logic [NR-1:0]    RBUSY,
  input  logic             ISS_EN,
  input  logic [AW-1:0]    ISS_A,
  output logic [AW:0]      NBUSY
);
  localparam int DEPTH = 2**AW;

  logic [DEPTH-1:0][DW-1:0] rf;
  logic [DEPTH-1:0]         busy, busy_nxt;
  logic [DEPTH-1:0]         hit_a, hit_b, hit_iss;
  logic [AW:0]              cnt_nxt;

  always_comb begin
    hit_a   = '0;
    hit_b   = '0;
    hit_iss = '0;
    for (int n = 1; n < DEPTH; n++) begin
      hit_a[n]   = WE_A   && (WA_A  == AW'(n));
      hit_b[n]   = WE_B   && (WA_B  == AW'(n));
      hit_iss[n] = ISS_EN && (ISS_A == AW'(n));
    end
  end

  // Issue beats writeback on the same register: the new producer owns it.
  always_comb begin
    busy_nxt = '0;
    for (int n = 1; n < DEPTH; n++)
      busy_nxt[n] = hit_iss[n] | (busy[n] & ~(hit_a[n] | hit_b[n]));
  end

  always_comb begin
    cnt_nxt = '0;
    for (int n = 0; n < DEPTH; n++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[n]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf    <= '0;
      busy  <= '0;
      NBUSY <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (hit_b[n])      rf[n] <= WD_B;
        else if (hit_a[n]) rf[n] <= WD_A;
      end
      busy  <= busy_nxt;
      NBUSY <= cnt_nxt;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NR; i++) begin : g_rd
      regfile_mp_rd #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_rd (
        .ra    (RA[i*AW +: AW]),
        .we_a  (WE_A),
        .wa_a  (WA_A),
        .wd_a  (WD_A),
        .we_b  (WE_B),
        .wa_b  (WA_B),
        .wd_b  (WD_B),
        .rf    (rf),
        .busy  (busy),
        .rd    (RD[i*DW +: DW]),
        .rbusy (RBUSY[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, r0, bypass/priority, scoreboard, set-wins, fill/drain.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 3;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             WE_A, WE_B, ISS_EN;
  logic [AW-1:0]    WA_A, WA_B, ISS_A;
  logic [DW-1:0]    WD_A, WD_B;
  logic [AW-1:0]    ra [NR];
  logic [NR*AW-1:0] RA;
  logic [NR*DW-1:0] RD;
  logic [NR-1:0]    RBUSY;
  logic [AW:0]      NBUSY;

  int total = 0;
  int passed = 0;

  assign RA = {ra[2], ra[1], ra[0]};

  always #5 CLK = ~CLK;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .RA(RA), .RD(RD), .RBUSY(RBUSY),
    .ISS_EN(ISS_EN), .ISS_A(ISS_A), .NBUSY(NBUSY)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] rdp(input int p);
    return RD[p*DW +: DW];
  endfunction

  task automatic idle();
    WE_A = 0; WE_B = 0; ISS_EN = 0;
    WA_A = '0; WA_B = '0; ISS_A = '0;
    WD_A = '0; WD_B = '0;
  endtask

  // Inputs change #1 after the rising edge; checks happen between edges.
  task automatic step();
    @(posedge CLK); #1;
  endtask

  initial begin
    RST_N = 0;
    idle();
    ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0;
    #2;
    chk("rst_nbusy", 64'(NBUSY), 64'd0);
    chk("rst_rd0", 64'(rdp(0)), 64'd0);
    step(); step();
    RST_N = 1;
    step();

    // Zero register: writes and issue to r0 are discarded.
    WE_A = 1; WA_A = 5'd0; WD_A = 32'h12345678;
    ISS_EN = 1; ISS_A = 5'd0;
    #1;
    chk("r0_rd_same", 64'(rdp(0)), 64'd0);
    chk("r0_rbusy", 64'(RBUSY[0]), 64'd0);
    step(); idle(); #1;
    chk("r0_rd_after", 64'(rdp(0)), 64'd0);
    chk("r0_nbusy", 64'(NBUSY), 64'd0);

    // Same-address write on both ports: B wins.
    ra[0] = 5'd7;
    WE_A = 1; WA_A = 5'd7; WD_A = 32'h11;
    WE_B = 1; WA_B = 5'd7; WD_B = 32'h22;
    #1;
    chk("prio_bypass", 64'(rdp(0)), 64'h22);
    step(); idle(); #1;
    chk("prio_stored", 64'(rdp(0)), 64'h22);

    ra[1] = 5'd8;
    WE_A = 1; WA_A = 5'd8; WD_A = 32'h33;
    #1;
    chk("bypass_a", 64'(rdp(1)), 64'h33);
    step(); idle(); #1;
    chk("stored_a", 64'(rdp(1)), 64'h33);
    chk("r7_kept", 64'(rdp(0)), 64'h22);

    // Scoreboard: issue r3, write it back a few cycles later.
    ra[2] = 5'd3;
    ISS_EN = 1; ISS_A = 5'd3;
    #1;
    chk("iss_same_cycle", 64'(RBUSY[2]), 64'd0);
    step(); idle(); #1;
    chk("sb_busy", 64'(RBUSY[2]), 64'd1);
    chk("sb_nbusy1", 64'(NBUSY), 64'd1);
    step(); step(); #1;
    chk("sb_busy_hold", 64'(RBUSY[2]), 64'd1);
    WE_A = 1; WA_A = 5'd3; WD_A = 32'hA5;
    #1;
    chk("sb_wb_rbusy", 64'(RBUSY[2]), 64'd0);
    chk("sb_wb_rd", 64'(rdp(2)), 64'hA5);
    chk("sb_wb_nbusy_pre", 64'(NBUSY), 64'd1);
    step(); idle(); #1;
    chk("sb_nbusy0", 64'(NBUSY), 64'd0);
    chk("sb_rbusy_after", 64'(RBUSY[2]), 64'd0);
    chk("sb_rd_after", 64'(rdp(2)), 64'hA5);

    // Set wins over clear on the same edge.
    ra[0] = 5'd9;
    ISS_EN = 1; ISS_A = 5'd9;
    step(); idle(); #1;
    chk("sw_nbusy1", 64'(NBUSY), 64'd1);
    WE_B = 1; WA_B = 5'd9; WD_B = 32'h55;
    ISS_EN = 1; ISS_A = 5'd9;
    #1;
    chk("sw_rbusy_same", 64'(RBUSY[0]), 64'd0);
    step(); idle(); #1;
    chk("sw_rd", 64'(rdp(0)), 64'h55);
    chk("sw_rbusy", 64'(RBUSY[0]), 64'd1);
    chk("sw_nbusy", 64'(NBUSY), 64'd1);
    WE_A = 1; WA_A = 5'd9; WD_A = 32'h56;
    step(); idle(); #1;
    chk("sw_clear_nbusy", 64'(NBUSY), 64'd0);
    chk("sw_clear_rd", 64'(rdp(0)), 64'h56);

    // Fill: issue r1..r31, then drain two per cycle.
    for (int n = 1; n < 32; n++) begin
      ISS_EN = 1; ISS_A = AW'(n);
      step();
      if (n == 10) chk("fill_nbusy10", 64'(NBUSY), 64'd10);
    end
    idle(); #1;
    chk("fill_nbusy31", 64'(NBUSY), 64'd31);
    for (int k = 0; k < 16; k++) begin
      WE_A = 1; WA_A = AW'(2*k+1); WD_A = 32'h1000 + 32'(2*k+1);
      if (k < 15) begin
        WE_B = 1; WA_B = AW'(2*k+2); WD_B = 32'h1000 + 32'(2*k+2);
      end
      step(); idle(); #1;
      chk($sformatf("drain_nbusy_%0d", k), 64'(NBUSY), 64'((k < 15) ? 31 - 2*(k+1) : 0));
    end
    for (int n = 1; n < 32; n++) begin
      ra[n % 3] = AW'(n);
      #1;
      chk($sformatf("fill_rd_r%0d", n), 64'(rdp(n % 3)), 64'(32'h1000 + 32'(n)));
      chk($sformatf("fill_rbusy_r%0d", n), 64'(RBUSY[n % 3]), 64'd0);
    end

    // Asynchronous reset mid-cycle with live busy state.
    ra[0] = 5'd5; ra[1] = 5'd5; ra[2] = 5'd0;
    WE_A = 1; WA_A = 5'd5; WD_A = 32'hDEADBEEF;
    step(); idle();
    ISS_EN = 1; ISS_A = 5'd5;
    step(); idle(); #1;
    chk("pre_rst_rd", 64'(rdp(0)), 64'hDEADBEEF);
    chk("pre_rst_busy", 64'(RBUSY[0]), 64'd1);
    chk("pre_rst_nbusy", 64'(NBUSY), 64'd1);
    #1 RST_N = 0;
    #1;
    chk("arst_rd", 64'(rdp(0)), 64'd0);
    chk("arst_rbusy", 64'(RBUSY[0]), 64'd0);
    chk("arst_nbusy", 64'(NBUSY), 64'd0);
    WE_A = 1; WA_A = 5'd5; WD_A = 32'h77;
    ISS_EN = 1; ISS_A = 5'd6;
    #1;
    chk("arst_bypass", 64'(rdp(1)), 64'h77);
    step(); idle(); #1;
    chk("arst_wr_ignored", 64'(rdp(1)), 64'd0);
    chk("arst_iss_ignored", 64'(NBUSY), 64'd0);
    RST_N = 1;
    ISS_EN = 1; ISS_A = 5'd5;
    step(); idle(); #1;
    chk("rel_iss", 64'(RBUSY[0]), 64'd1);
    chk("rel_nbusy", 64'(NBUSY), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
